fetch_stage: RTL and testbench

Instruction-fetch stage that owns the program counter and drives the combinational instruction-memory read port (64-bit word address in, 32-bit instruction out, 32 words deep). It registers each fetched instruction with its PC into a single-entry output register. The output register uses a valid/ready handshake towards decode. It accepts PC redirects from later stages and halts on fetch faults.

---
 rtl/fetch_stage.sv | 177 +++++++++++++++++
 tb/tb_fetch_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage. Owns the program counter, drives a combinational
// instruction-memory read port and captures each fetched word together with
// its PC into a single-entry output register that hands off to decode through
// a valid/ready handshake. Later stages can redirect the PC at any time. A
// misaligned or out-of-range fetch is delivered to decode as a faulting
// entry (instruction forced to zero), and fetch then halts until the next
// redirect.
//
// Parameters
//   RESET_PC    byte address loaded into the PC on reset
//   IMEM_DEPTH  number of 32-bit words in instruction memory
//
// Ports
//   clk             rising-edge clock
//   rst_n           synchronous active-low reset
//   imem_addr       word address to instruction memory, {2'b00, pc[63:2]}
//   imem_data       instruction word returned combinationally for imem_addr
//   redirect_valid  load redirect_pc into the PC this cycle
//   redirect_pc     byte-address redirect target
//   id_ready        decode accepts the output register this cycle
//   if_valid        output register holds a fetch
//   if_instr        fetched instruction (zero for a faulting fetch)
//   if_pc           byte PC of if_instr
//   if_fault        fetch was misaligned or out of range
//   halted          fetch is stopped after a fault
//   fetch_count     number of handshakes accepted by decode (wraps at 2^32)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_DEPTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [63:0] if_pc,
    output logic        if_fault,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [0:0] {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    logic [63:0] r_pc;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic [63:0] r_if_pc;
    logic        r_if_fault;
    logic [31:0] r_fetch_count;

    logic [63:0] w_word_addr;
    logic        w_fault;
    logic        w_load;
    logic        w_accept;
    logic        w_halted;

    // Word address, fault detection and load/accept qualifiers from current pc.
    always_comb begin
        w_word_addr = {2'b00, r_pc[63:2]};
        w_fault     = (r_pc[1:0] != 2'b00) || (w_word_addr >= 64'(IMEM_DEPTH));
        // The output register can be refilled when it is empty or being drained.
        w_load      = (r_state == S_RUN) && (!r_if_valid || id_ready);
        w_accept    = r_if_valid && id_ready;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic; a redirect outranks a faulting load.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RUN: begin
                if (redirect_valid) begin
                    w_next_state = S_RUN;
                end else if (w_load && w_fault) begin
                    w_next_state = S_HALT;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    w_next_state = S_RUN;
                end else begin
                    w_next_state = S_HALT;
                end
            end
            default: begin
                w_next_state = S_RUN;
            end
        endcase
    end

    // FSM output decode.
    always_comb begin
        w_halted = 1'b0;
        case (r_state)
            S_RUN:   w_halted = 1'b0;
            S_HALT:  w_halted = 1'b1;
            default: w_halted = 1'b0;
        endcase
    end

    // PC and output register: priority reset, redirect, load, drain, hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_instr <= 32'h0;
            r_if_pc    <= 64'h0;
            r_if_fault <= 1'b0;
        end else if (redirect_valid) begin
            // Any pending entry is dropped; instr/pc keep their stale values.
            r_pc       <= redirect_pc;
            r_if_valid <= 1'b0;
            r_if_fault <= 1'b0;
        end else if (w_load) begin
            r_if_valid <= 1'b1;
            r_if_pc    <= r_pc;
            if (w_fault) begin
                // Memory data is meaningless here; pc stays on the bad address.
                r_if_instr <= 32'h0;
                r_if_fault <= 1'b1;
            end else begin
                r_if_instr <= imem_data;
                r_if_fault <= 1'b0;
                r_pc       <= r_pc + 64'd4;
            end
        end else if (w_accept) begin
            // Only reachable in HALT: decode drains the entry, nothing refills it.
            r_if_valid <= 1'b0;
        end else begin
            r_if_valid <= r_if_valid;
        end
    end

    // Handshake counter; a redirect does not cancel an accepted transfer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_count <= 32'd0;
        end else if (w_accept) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end else begin
            r_fetch_count <= r_fetch_count;
        end
    end

    assign imem_addr   = w_word_addr;
    assign if_valid    = r_if_valid;
    assign if_instr    = r_if_instr;
    assign if_pc       = r_if_pc;
    assign if_fault    = r_if_fault;
    assign halted      = w_halted;
    assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    typedef struct {
        logic        sel;      // 0: DUT with RESET_PC=0, 1: DUT with RESET_PC=0x7C
        logic        rst_n;
        logic        rdv;
        logic [63:0] rpc;
        logic        idr;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_fault;
        logic        e_halted;
        logic [31:0] e_cnt;
        logic [63:0] e_addr;
    } vec_t;

    logic clk;
    logic [31:0] mem [32];

    // DUT 0 signals
    logic        rst_n0, rdv0, idr0;
    logic [63:0] rpc0, addr0, pc0;
    logic [31:0] data0, instr0, cnt0;
    logic        valid0, fault0, halted0;
    // DUT 1 signals
    logic        rst_n1, rdv1, idr1;
    logic [63:0] rpc1, addr1, pc1;
    logic [31:0] data1, instr1, cnt1;
    logic        valid1, fault1, halted1;

    int errors = 0;
    int checks = 0;
    vec_t tbl[28];
    vec_t exp_q[$];

    // Memory model: out-of-range reads return a marker that must never be captured.
    assign data0 = (addr0 < 64'd32) ? mem[addr0[4:0]] : 32'hDEADBEEF;
    assign data1 = (addr1 < 64'd32) ? mem[addr1[4:0]] : 32'hDEADBEEF;

    fetch_stage #(.RESET_PC(64'h0), .IMEM_DEPTH(32)) dut0 (
        .clk(clk), .rst_n(rst_n0), .imem_addr(addr0), .imem_data(data0),
        .redirect_valid(rdv0), .redirect_pc(rpc0), .id_ready(idr0),
        .if_valid(valid0), .if_instr(instr0), .if_pc(pc0), .if_fault(fault0),
        .halted(halted0), .fetch_count(cnt0)
    );

    fetch_stage #(.RESET_PC(64'h7C), .IMEM_DEPTH(32)) dut1 (
        .clk(clk), .rst_n(rst_n1), .imem_addr(addr1), .imem_data(data1),
        .redirect_valid(rdv1), .redirect_pc(rpc1), .id_ready(idr1),
        .if_valid(valid1), .if_instr(instr1), .if_pc(pc1), .if_fault(fault1),
        .halted(halted1), .fetch_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic sel, input logic rst, input logic rdv,
                                input logic [63:0] rpc, input logic idr,
                                input logic v, input logic [31:0] ins, input logic [63:0] pc,
                                input logic f, input logic h, input logic [31:0] c,
                                input logic [63:0] a);
        vec_t r;
        r.sel = sel; r.rst_n = rst; r.rdv = rdv; r.rpc = rpc; r.idr = idr;
        r.e_valid = v; r.e_instr = ins; r.e_pc = pc; r.e_fault = f;
        r.e_halted = h; r.e_cnt = c; r.e_addr = a;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one vector, queue its expectation, pop and compare after the edge.
    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge clk);
        if (v.sel == 1'b0) begin
            rst_n0 = v.rst_n; rdv0 = v.rdv; rpc0 = v.rpc; idr0 = v.idr;
        end else begin
            rst_n1 = v.rst_n; rdv1 = v.rdv; rpc1 = v.rpc; idr1 = v.idr;
        end
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        if (e.sel == 1'b0) begin
            chk("if_valid",    idx, {63'd0, valid0},  {63'd0, e.e_valid});
            chk("if_instr",    idx, {32'd0, instr0},  {32'd0, e.e_instr});
            chk("if_pc",       idx, pc0,              e.e_pc);
            chk("if_fault",    idx, {63'd0, fault0},  {63'd0, e.e_fault});
            chk("halted",      idx, {63'd0, halted0}, {63'd0, e.e_halted});
            chk("fetch_count", idx, {32'd0, cnt0},    {32'd0, e.e_cnt});
            chk("imem_addr",   idx, addr0,            e.e_addr);
        end else begin
            chk("if_valid",    idx, {63'd0, valid1},  {63'd0, e.e_valid});
            chk("if_instr",    idx, {32'd0, instr1},  {32'd0, e.e_instr});
            chk("if_pc",       idx, pc1,              e.e_pc);
            chk("if_fault",    idx, {63'd0, fault1},  {63'd0, e.e_fault});
            chk("halted",      idx, {63'd0, halted1}, {63'd0, e.e_halted});
            chk("fetch_count", idx, {32'd0, cnt1},    {32'd0, e.e_cnt});
            chk("imem_addr",   idx, addr1,            e.e_addr);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i);
        mem[0] = 32'd15; mem[1] = 32'd64; mem[2] = 32'd89; mem[3] = 32'd1; mem[4] = 32'd73;

        rst_n0 = 1'b0; rdv0 = 1'b0; rpc0 = 64'h0; idr0 = 1'b1;
        rst_n1 = 1'b0; rdv1 = 1'b0; rpc1 = 64'h0; idr1 = 1'b1;

        //              sel  rst  rdv  rpc      idr  valid instr     pc      flt  hlt  cnt    addr
        // Reset, then streaming fetch of words 0..5
        tbl[0]  = mk(1'b0,1'b0,1'b0,64'h0,   1'b1,1'b0,32'd0,    64'd0,  1'b0,1'b0,32'd0, 64'd0);
        tbl[1]  = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd15,   64'd0,  1'b0,1'b0,32'd0, 64'd1);
        tbl[2]  = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd64,   64'd4,  1'b0,1'b0,32'd1, 64'd2);
        tbl[3]  = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd89,   64'd8,  1'b0,1'b0,32'd2, 64'd3);
        tbl[4]  = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd1,    64'd12, 1'b0,1'b0,32'd3, 64'd4);
        tbl[5]  = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd73,   64'd16, 1'b0,1'b0,32'd4, 64'd5);
        tbl[6]  = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'h105,  64'd20, 1'b0,1'b0,32'd5, 64'd6);
        // Redirect to 0 while an accepted entry is pending: counted, then dropped
        tbl[7]  = mk(1'b0,1'b1,1'b1,64'h0,   1'b1,1'b0,32'h105,  64'd20, 1'b0,1'b0,32'd6, 64'd0);
        tbl[8]  = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd15,   64'd0,  1'b0,1'b0,32'd6, 64'd1);
        tbl[9]  = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd64,   64'd4,  1'b0,1'b0,32'd7, 64'd2);
        // Three stall cycles with if_pc=4
        tbl[10] = mk(1'b0,1'b1,1'b0,64'h0,   1'b0,1'b1,32'd64,   64'd4,  1'b0,1'b0,32'd7, 64'd2);
        tbl[11] = mk(1'b0,1'b1,1'b0,64'h0,   1'b0,1'b1,32'd64,   64'd4,  1'b0,1'b0,32'd7, 64'd2);
        tbl[12] = mk(1'b0,1'b1,1'b0,64'h0,   1'b0,1'b1,32'd64,   64'd4,  1'b0,1'b0,32'd7, 64'd2);
        tbl[13] = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd89,   64'd8,  1'b0,1'b0,32'd8, 64'd3);
        // Redirect to 0x10 while stalled
        tbl[14] = mk(1'b0,1'b1,1'b1,64'h10,  1'b0,1'b0,32'd89,   64'd8,  1'b0,1'b0,32'd8, 64'd4);
        tbl[15] = mk(1'b0,1'b1,1'b0,64'h0,   1'b0,1'b1,32'd73,   64'd16, 1'b0,1'b0,32'd8, 64'd5);
        tbl[16] = mk(1'b0,1'b1,1'b0,64'h0,   1'b0,1'b1,32'd73,   64'd16, 1'b0,1'b0,32'd8, 64'd5);
        // Misaligned redirect target 0x6 faults on the next fetch and halts
        tbl[17] = mk(1'b0,1'b1,1'b1,64'h6,   1'b1,1'b0,32'd73,   64'd16, 1'b0,1'b0,32'd9, 64'd1);
        tbl[18] = mk(1'b0,1'b1,1'b0,64'h0,   1'b0,1'b1,32'd0,    64'd6,  1'b1,1'b1,32'd9, 64'd1);
        tbl[19] = mk(1'b0,1'b1,1'b0,64'h0,   1'b0,1'b1,32'd0,    64'd6,  1'b1,1'b1,32'd9, 64'd1);
        tbl[20] = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b0,32'd0,    64'd6,  1'b1,1'b1,32'd10,64'd1);
        tbl[21] = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b0,32'd0,    64'd6,  1'b1,1'b1,32'd10,64'd1);
        // Reset coincident with redirect: reset wins
        tbl[22] = mk(1'b0,1'b0,1'b1,64'h40,  1'b1,1'b0,32'd0,    64'd0,  1'b0,1'b0,32'd0, 64'd0);
        tbl[23] = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd15,   64'd0,  1'b0,1'b0,32'd0, 64'd1);
        tbl[24] = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd64,   64'd4,  1'b0,1'b0,32'd1, 64'd2);
        // Reset in the middle of a stall
        tbl[25] = mk(1'b0,1'b1,1'b0,64'h0,   1'b0,1'b1,32'd64,   64'd4,  1'b0,1'b0,32'd1, 64'd2);
        tbl[26] = mk(1'b0,1'b0,1'b0,64'h0,   1'b0,1'b0,32'd0,    64'd0,  1'b0,1'b0,32'd0, 64'd0);
        tbl[27] = mk(1'b0,1'b1,1'b0,64'h0,   1'b1,1'b1,32'd15,   64'd0,  1'b0,1'b0,32'd0, 64'd1);

        for (int i = 0; i < 28; i++) apply(tbl[i], i);

        // Hand-written sequence on the RESET_PC=0x7C instance: last word, then
        // out-of-range fault, drain in HALT, and recovery through redirect.
        apply(mk(1'b1,1'b0,1'b0,64'h0,1'b1,1'b0,32'd0,   64'h0, 1'b0,1'b0,32'd0,64'h1F), 100);
        apply(mk(1'b1,1'b1,1'b0,64'h0,1'b1,1'b1,32'h11F, 64'h7C,1'b0,1'b0,32'd0,64'h20), 101);
        apply(mk(1'b1,1'b1,1'b0,64'h0,1'b1,1'b1,32'd0,   64'h80,1'b1,1'b1,32'd1,64'h20), 102);
        apply(mk(1'b1,1'b1,1'b0,64'h0,1'b1,1'b0,32'd0,   64'h80,1'b1,1'b1,32'd2,64'h20), 103);
        apply(mk(1'b1,1'b1,1'b0,64'h0,1'b1,1'b0,32'd0,   64'h80,1'b1,1'b1,32'd2,64'h20), 104);
        apply(mk(1'b1,1'b1,1'b1,64'h0,1'b1,1'b0,32'd0,   64'h80,1'b0,1'b0,32'd2,64'h0),  105);
        apply(mk(1'b1,1'b1,1'b0,64'h0,1'b1,1'b1,32'd15,  64'h0, 1'b0,1'b0,32'd2,64'h1),  106);
        apply(mk(1'b1,1'b1,1'b0,64'h0,1'b0,1'b1,32'd15,  64'h0, 1'b0,1'b0,32'd2,64'h1),  107);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
